// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: fetch FSM states, fault codes, opcodes.
// Imported by the fetch stage and the multicycle control unit.
package riscv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_FAULT
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    localparam logic [1:0] FAULT_NONE     = 2'd0;
    localparam logic [1:0] FAULT_MISALIGN = 2'd1;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'd2;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_JAL    = 7'h6F;

endpackage

// File: rtl/fetch_timer.sv
// Clearable 8-bit wait counter for the fetch stage.
// Terminal count flags when the count equals TIMEOUT_CYC.
module fetch_timer #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic tc
);

    logic [7:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            count <= 8'd0;
        else if (clear)
            count <= 8'd0;
        else if (inc)
            count <= count + 8'd1;
    end

    assign tc = (count == 8'(TIMEOUT_CYC));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, fetches over req/ack,
// and hands instruction, opcode and fetch PC to the control unit.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter logic [63:0] RESET_PC    = 64'h0,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fetch_start,
    input  logic        pc_load,
    input  logic [63:0] pc_next,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic [63:0] instr_pc,
    output logic        instr_valid,
    output logic        fetch_busy,
    output logic        fetch_fault,
    output logic [1:0]  fault_code
);

    fetch_state_t state;
    logic [63:0]  pc;
    logic         pend_valid;
    logic [63:0]  pend_pc;
    logic [63:0]  fetch_addr;
    logic         tmr_tc;

    // A same-cycle redirect is the address fetched.
    assign fetch_addr = pc_load ? pc_next : pc;
    assign opcode     = instr[6:0];
    assign fetch_busy = (state != ST_IDLE);

    fetch_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clock(clock),
        .reset(reset),
        .clear(state == ST_REQ),
        .inc  (state == ST_WAIT && !imem_ack),
        .tc   (tmr_tc)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            pc          <= RESET_PC;
            pend_valid  <= 1'b0;
            pend_pc     <= 64'd0;
            imem_req    <= 1'b0;
            imem_addr   <= 64'd0;
            instr       <= NOP_INSTR;
            instr_pc    <= 64'd0;
            instr_valid <= 1'b0;
            fetch_fault <= 1'b0;
            fault_code  <= FAULT_NONE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (pc_load)
                        pc <= pc_next;
                    if (fetch_start) begin
                        if (fetch_addr[1:0] != 2'b00) begin
                            state       <= ST_FAULT;
                            fetch_fault <= 1'b1;
                            fault_code  <= FAULT_MISALIGN;
                        end else begin
                            state       <= ST_REQ;
                            imem_addr   <= fetch_addr;
                            imem_req    <= 1'b1;
                            instr_valid <= 1'b0;
                        end
                    end
                end
                ST_REQ: begin
                    if (pc_load) begin
                        pend_valid <= 1'b1;
                        pend_pc    <= pc_next;
                    end
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        instr_pc    <= imem_addr;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        pend_valid  <= 1'b0;
                        state       <= ST_IDLE;
                        // Newest redirect wins, even on the ack cycle.
                        if (pc_load)
                            pc <= pc_next;
                        else if (pend_valid)
                            pc <= pend_pc;
                        else
                            pc <= imem_addr + 64'd4;
                    end else begin
                        if (pc_load) begin
                            pend_valid <= 1'b1;
                            pend_pc    <= pc_next;
                        end
                        if (tmr_tc) begin
                            imem_req    <= 1'b0;
                            fetch_fault <= 1'b1;
                            fault_code  <= FAULT_TIMEOUT;
                            state       <= ST_FAULT;
                        end
                    end
                end
                ST_FAULT: begin
                    state <= ST_FAULT;
                end
            endcase
        end
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage sitting directly upstream of the multicycle control unit and instruction register path. It owns the program counter, issues read requests to the instruction memory over a req/ack handshake, captures the returned 32-bit word, and presents instruction, opcode and instruction PC to the control unit. PC updates requested by the control unit, such as branch targets, are applied here.

## Interface
- `RESET_PC`, default 64'h0: PC value after reset.
- `TIMEOUT_CYC`, default 255: maximum wait cycles for `imem_ack` before a fault is raised; must be ≥1 and ≤255.
- `clock` in 1: clock. All state updates on the rising edge.
- `reset` in 1: reset, asynchronous, active-high.
- `fetch_start` in 1: single-cycle request from the control unit to fetch at the current PC.
- `pc_load` in 1: load `pc_next` into the PC.
- `pc_next` in 64: redirect target.
- `imem_req` out 1: memory read request. Registered.
- `imem_addr` out 64: read address. Registered, held stable while `imem_req`=1.
- `imem_ack` in 1: memory response valid. Sampled only while `imem_req`=1.
- `imem_rdata` in 32: read data, valid when `imem_ack`=1.
- `instr` out 32: captured instruction (Instr31_0).
- `opcode` out 7: equals `instr[6:0]`.
- `instr_pc` out 64: address that `instr` was fetched from.
- `instr_valid` out 1: `instr` holds a completed fetch.
- `fetch_busy` out 1: high in any state other than IDLE.
- `fetch_fault` out 1: sticky error flag, cleared only by reset.
- `fault_code` out 2: cause of the fault. 0 = none, 1 = misaligned, 2 = timeout.

## Operation
- The block has four states: IDLE, REQ, WAIT and FAULT.
- Reset values:
  - state = IDLE; `pc` = `RESET_PC`; `instr` = 32'h00000013 (NOP); `instr_pc` = 0.
  - `instr_valid`, `imem_req`, `fetch_fault` = 0; `fault_code` = 0; `imem_addr` = 0.
  - Pending-redirect register cleared.
- In IDLE:
  - If `pc_load`=1, then `pc` ← `pc_next`.
  - If `fetch_start`=1, the fetch address is `pc_next` when `pc_load`=1 in the same cycle, otherwise `pc`.
  - Address with bits [1:0] ≠ 0: go to FAULT with `fault_code`=1. No request is issued.
  - Aligned address: `imem_addr` ← address, `imem_req` ← 1, `instr_valid` ← 0, go to REQ.
- REQ: lasts one cycle. The timeout counter is cleared to 0, then the block goes to WAIT. `imem_req` stays high.
- In WAIT:
  - On `imem_ack`=1: `instr` ← `imem_rdata`, `instr_pc` ← `imem_addr`, `instr_valid` ← 1, `imem_req` ← 0, go to IDLE.
  - On that same ack, if a redirect is pending, `pc` ← pending target and the pending flag is cleared; otherwise `pc` ← `imem_addr` + 4, modulo 2^64.
  - With no ack: the counter increments. When it reaches `TIMEOUT_CYC`, `imem_req` ← 0, `fault_code` ← 2, go to FAULT.
- `pc_load` during REQ or WAIT is stored as a pending redirect. The last one received wins. It never aborts the fetch in flight.
- `fetch_start` while `fetch_busy`=1 is ignored. There is no queueing.
- FAULT is terminal until reset: `fetch_fault`=1, `imem_req`=0, and `fetch_start` and `pc_load` are ignored.
- `instr_valid`, once set, stays high until the next accepted `fetch_start`.
- `instr` and `instr_pc` change only on an ack.

## Timing
- The request appears one cycle after `fetch_start`: `fetch_start` in cycle 0 gives `imem_req`=1 in cycle 1.
- An ack sampled at the edge ending cycle k gives `instr_valid`=1 and the new `instr` in cycle k+1.
- The earliest ack arrives in cycle 2, so minimum fetch latency is 3 cycles from `fetch_start` to `instr_valid`.
- `imem_req` drops in the cycle after the ack. Memory must not present a second ack for the same request.
- Timeout: with `fetch_start` in cycle 0 and no ack, FAULT is entered at the edge ending cycle 2+`TIMEOUT_CYC`.
- An ack arriving in the same cycle the counter hits `TIMEOUT_CYC` counts as success; the ack wins.
- Reset mid-fetch aborts the fetch asynchronously: `imem_req` drops immediately. A later stray ack is ignored because the block is in IDLE.

## Structure
- Shared `riscv_pkg`:
  - `fetch_state_t` enum covering IDLE, REQ, WAIT and FAULT.
  - `NOP_INSTR` = 32'h00000013.
  - `FAULT_NONE`, `FAULT_MISALIGN`, `FAULT_TIMEOUT` constants.
  - RV opcode constants, shared with the control unit.
- One sub-module, `fetch_timer`: 8-bit clearable counter with a terminal-count output compared against `TIMEOUT_CYC`.
- The FSM and the PC/IR registers stay in `instr_fetch`.

## Test plan
- Basic fetch: reset, `fetch_start`, memory acks in cycle 2 with 32'h00500093.
  - `instr`=32'h00500093, `opcode`=7'h13, `instr_pc`=0, `pc`=4, `instr_valid` rises in cycle 3.
- Slow memory: ack after 10 wait cycles. `imem_addr` stays stable throughout, no fault, `pc` advances by 4.
- Redirect during WAIT: `pc_load` with `pc_next`=64'h100 while waiting; ack returns 32'h00000013.
  - `instr_pc`=0, `pc`=64'h100 afterwards, and the next fetch uses `imem_addr`=64'h100.
- Misaligned fetch: `pc_load` with `pc_next`=64'h102 and `fetch_start` in the same cycle.
  - `imem_req` never rises, `fetch_fault`=1, `fault_code`=1.
- Timeout with `TIMEOUT_CYC`=4 and no ack: `fault_code`=2 exactly 6 cycles after `fetch_start`, then `imem_req`=0.
  - Repeat with the ack on the terminal cycle: success, no fault.
- Reset mid-fetch: assert `reset` while in WAIT.
  - All outputs return to their reset values asynchronously, `pc`=`RESET_PC`, and a following ack has no effect.
